imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 171 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32 immediate generator feeding a DEPTH-entry result queue with valid/ready handshakes.
// Optional illegal-opcode counter is compiled in with `define IMM_GEN_ERRCNT_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruct,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic [2:0]      fmt,
    output logic            illegal
`ifdef IMM_GEN_ERRCNT_EN
    ,
    output logic [15:0]     err_count
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    function automatic logic [2:0] decode_fmt(input logic [6:0] op);
        logic [2:0] f;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: f = FMT_I;
            7'b0100011:                         f = FMT_S;
            7'b1100011:                         f = FMT_B;
            7'b0110111, 7'b0010111:             f = FMT_U;
            7'b1101111:                         f = FMT_J;
            7'b0110011:                         f = FMT_R;
            default:                            f = FMT_ILL;
        endcase
        return f;
    endfunction

    // Every immediate is first formed as a signed 32-bit value, then widened from bit 31.
    function automatic logic [XLEN-1:0] build_imm(input logic [31:0] inst, input logic [2:0] f);
        logic [31:0]     imm32;
        logic [XLEN-1:0] res;
        case (f)
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'h000};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = 32'h0000_0000;
        endcase
        res       = {XLEN{imm32[31]}};
        res[31:0] = imm32;
        return res;
    endfunction

    logic [XLEN-1:0] out_mem_r [DEPTH];
    logic [2:0]      fmt_mem_r [DEPTH];
    logic            ill_mem_r [DEPTH];
    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;

    logic [2:0]      dec_fmt_s;
    logic [XLEN-1:0] dec_imm_s;
    logic            dec_ill_s;
    logic            push_s;
    logic            pop_s;
    logic            in_ready_s;
    logic            out_valid_s;

    // Decode the incoming word; only the queue register stands between it and the head.
    always_comb begin
        dec_fmt_s = decode_fmt(instruct[6:0]);
        dec_imm_s = build_imm(instruct, dec_fmt_s);
        dec_ill_s = (dec_fmt_s == FMT_ILL);
    end

    // Handshake qualifiers derive only from the registered occupancy.
    always_comb begin
        in_ready_s  = (count_r < FULL_CNT);
        out_valid_s = (count_r != CW'(0));
        push_s      = in_valid & in_ready_s;
        pop_s       = out_valid_s & out_ready;
    end

    // Queue storage: written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                out_mem_r[i] <= {XLEN{1'b0}};
                fmt_mem_r[i] <= 3'd0;
                ill_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            out_mem_r[wptr_r] <= dec_imm_s;
            fmt_mem_r[wptr_r] <= dec_fmt_s;
            ill_mem_r[wptr_r] <= dec_ill_s;
        end else begin
            out_mem_r[wptr_r] <= out_mem_r[wptr_r];
        end
    end

    // Wrapping pointers and occupancy count; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= PW'(0);
            rptr_r  <= PW'(0);
            count_r <= CW'(0);
        end else begin
            if (push_s) begin
                wptr_r <= (wptr_r == LAST_PTR) ? PW'(0) : wptr_r + PW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= (rptr_r == LAST_PTR) ? PW'(0) : rptr_r + PW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head view is forced to zero whenever the queue is empty.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = out_valid_s;
        if (out_valid_s) begin
            out     = out_mem_r[rptr_r];
            fmt     = fmt_mem_r[rptr_r];
            illegal = ill_mem_r[rptr_r];
        end else begin
            out     = {XLEN{1'b0}};
            fmt     = 3'd0;
            illegal = 1'b0;
        end
    end

`ifdef IMM_GEN_ERRCNT_EN
    logic [15:0] err_cnt_r;

    // Saturating count of accepted illegal instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 16'h0000;
        end else if (push_s && dec_ill_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'h0001;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_count = err_cnt_r;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table, back-pressure, mid-run reset and a 64-bit instance.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruct;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [2:0]  fmt;
    logic        illegal;

    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] instruct64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out64;
    logic [2:0]  fmt64;
    logic        illegal64;

`ifdef IMM_GEN_ERRCNT_EN
    logic [15:0] err_count;
    logic [15:0] err_count64;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .instruct(instruct),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .fmt(fmt), .illegal(illegal)
`ifdef IMM_GEN_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(1)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid64), .in_ready(in_ready64), .instruct(instruct64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .out(out64), .fmt(fmt64), .illegal(illegal64)
`ifdef IMM_GEN_ERRCNT_EN
        , .err_count(err_count64)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  f;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic [31:0] imm, input logic [2:0] f,
                              input logic ill);
        check({name, ".valid"}, 64'(out_valid), 64'd1);
        check({name, ".out"}, 64'(out), 64'(imm));
        check({name, ".fmt"}, 64'(fmt), 64'(f));
        check({name, ".illegal"}, 64'(illegal), 64'(ill));
    endtask

    int exp_err;

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0}; // addi -1
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0}; // sw -4
        vecs[2]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0}; // lui
        vecs[3]  = '{32'h0000FFFF, 32'h00000000, 3'd7, 1'b1};
        vecs[4]  = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0}; // add
        vecs[5]  = '{32'h80000063, 32'hFFFFF000, 3'd3, 1'b0};
        vecs[6]  = '{32'h00000FE3, 32'h0000081E, 3'd3, 1'b0};
        vecs[7]  = '{32'h8000006F, 32'hFFF00000, 3'd5, 1'b0};
        vecs[8]  = '{32'h7FE0006F, 32'h000007FE, 3'd5, 1'b0};
        vecs[9]  = '{32'h000FF06F, 32'h000FF000, 3'd5, 1'b0};
        vecs[10] = '{32'h00402083, 32'h00000004, 3'd1, 1'b0}; // lw
        vecs[11] = '{32'h7FF080E7, 32'h000007FF, 3'd1, 1'b0}; // jalr
        vecs[12] = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0}; // auipc
        vecs[13] = '{32'h0000000B, 32'h00000000, 3'd7, 1'b1};
        vecs[14] = '{32'h00000000, 32'h00000000, 3'd7, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; instruct = 32'd0; out_ready = 1'b0;
        in_valid64 = 1'b0; instruct64 = 32'd0; out_ready64 = 1'b0;
        #2;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.out", 64'(out), 64'd0);
        check("rst.fmt", 64'(fmt), 64'd0);
        check("rst.illegal", 64'(illegal), 64'd0);
`ifdef IMM_GEN_ERRCNT_EN
        check("rst.err_count", 64'(err_count), 64'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Table: push one, check the head one edge later, then pop it back to empty.
        exp_err = 0;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            instruct = vecs[i].inst;
            tick();
            in_valid = 1'b0;
            check_head($sformatf("vec%0d", i), vecs[i].imm, vecs[i].f, vecs[i].ill);
            check($sformatf("vec%0d.in_ready", i), 64'(in_ready), 64'd1);
            if (vecs[i].ill) exp_err++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check($sformatf("vec%0d.drained", i), 64'(out_valid), 64'd0);
            check($sformatf("vec%0d.empty_out", i), 64'(out), 64'd0);
        end
`ifdef IMM_GEN_ERRCNT_EN
        check("err_count.table", 64'(err_count), 64'(exp_err));
`endif

        // Back-pressure: three pushes into a two-entry queue with the consumer stalled.
        in_valid = 1'b1; instruct = 32'hFFF00093;
        tick();
        check("bp.in_ready1", 64'(in_ready), 64'd1);
        check_head("bp.headA1", 32'hFFFFFFFF, 3'd1, 1'b0);
        instruct = 32'h123450B7;
        tick();
        check("bp.in_ready2", 64'(in_ready), 64'd0);
        check_head("bp.headA2", 32'hFFFFFFFF, 3'd1, 1'b0);
        instruct = 32'h0000FFFF;
        tick();
        check("bp.held_ready", 64'(in_ready), 64'd0);
        check_head("bp.headA3", 32'hFFFFFFFF, 3'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        check_head("bp.headB", 32'h12345000, 3'd4, 1'b0);
        check("bp.ready_after_pop", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_head("bp.headC", 32'h00000000, 3'd7, 1'b1);
        tick();
        out_ready = 1'b0;
        check("bp.empty", 64'(out_valid), 64'd0);
`ifdef IMM_GEN_ERRCNT_EN
        check("err_count.bp", 64'(err_count), 64'(exp_err + 1));
`endif

        // Reset with two entries queued must clear without a clock edge.
        in_valid = 1'b1; instruct = 32'h0000FFFF;
        tick();
        instruct = 32'hFE112E23;
        tick();
        in_valid = 1'b0;
        check("mid.full", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.out_valid", 64'(out_valid), 64'd0);
        check("mid.in_ready", 64'(in_ready), 64'd1);
        check("mid.out", 64'(out), 64'd0);
        check("mid.fmt", 64'(fmt), 64'd0);
        check("mid.illegal", 64'(illegal), 64'd0);
`ifdef IMM_GEN_ERRCNT_EN
        check("mid.err_count", 64'(err_count), 64'd0);
`endif
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; instruct = 32'h00402083;
        tick();
        in_valid = 1'b0;
        check_head("post.head", 32'h00000004, 3'd1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post.single", 64'(out_valid), 64'd0);

        // 64-bit, single-entry instance.
        in_valid64 = 1'b1; instruct64 = 32'h80000037;
        tick();
        in_valid64 = 1'b0;
        check("x64.valid", 64'(out_valid64), 64'd1);
        check("x64.lui", out64, 64'hFFFFFFFF80000000);
        check("x64.fmt", 64'(fmt64), 64'd4);
        check("x64.illegal", 64'(illegal64), 64'd0);
        check("x64.full", 64'(in_ready64), 64'd0);
        out_ready64 = 1'b1; in_valid64 = 1'b1; instruct64 = 32'hFFF00093;
        tick();
        check("x64.full_pop_only", 64'(out_valid64), 64'd0);
        tick();
        in_valid64 = 1'b0;
        check("x64.addi", out64, 64'hFFFFFFFFFFFFFFFF);
        tick();
        out_ready64 = 1'b0;
        check("x64.empty", 64'(out_valid64), 64'd0);
`ifdef IMM_GEN_ERRCNT_EN
        check("x64.err_count", 64'(err_count64), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
